ex_muldiv_unit: RTL and testbench
=================================

# ex_muldiv_unit

Iterative multiply/divide unit for the EX stage, with architectural HI/LO registers. It accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO operation per start and raises a stall request toward the stall detector while an operation is in flight. HI/LO are updated atomically when the operation completes. The EX stage reads them through a mux gated by the stall request. Width and multiplier throughput are parameters, and EX-stage flush aborts an in-flight operation.

## Interface
- WIDTH, 32: operand and HI/LO width; must be even and ≥ 8.
- MUL_BITS, 1: multiplier bits retired per cycle; one of 1, 2, 4, 8; must divide WIDTH.
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous, active-low reset (rst==0 at posedge resets).
- start  in  1  EX holds a valid md instruction (func != NONE).
- func  in  3  md_func_e: 0 NONE, 1 MUL, 2 DIV, 3 MTHI, 4 MTLO; 5–7 are treated as NONE.
- is_sign  in  1  signed MUL/DIV when 1.
- a  in  WIDTH  rs operand (forwarded), the dividend or multiplicand.
- b  in  WIDTH  rt operand (forwarded), the divisor or multiplier.
- hilo_read  in  1  EX instruction reads HI or LO (MFHI/MFLO).
- flush  in  1  EX_FLUSH from the controller.
- hi, lo  out  WIDTH  architectural HI/LO registers.
- busy  out  1  FSM not IDLE.
- done  out  1  one-cycle pulse on the cycle HI/LO take a MUL/DIV result.
- stall_req  out  1  combinational: busy || (start && func∈{MUL,DIV} && !flush) || (hilo_read && busy).

## Operation
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE:
  - start with MUL or DIV latches |a|, |b| (magnitudes when is_sign, raw otherwise), the result-sign flags and the counter, then moves to the MUL or DIV state.
  - MTHI/MTLO write a into hi/lo at the posedge and stay IDLE; stall_req is not raised.
- MUL: shift-add over MUL_BITS multiplier bits per cycle, giving a 2·WIDTH accumulator. Runs for WIDTH/MUL_BITS cycles, then moves to FIX.
- DIV: restoring division, 1 quotient bit per cycle. Runs for WIDTH cycles, then moves to FIX.
- FIX: applies the sign correction:
  - The product is negated if sign(a)≠sign(b).
  - The quotient is negated if the signs differ; the remainder takes the sign of a.
  - {hi,lo} is written; for DIV, lo=quotient and hi=remainder.
  - done=1 and the FSM returns to IDLE.
- Divide by zero: hi=a (unmodified input), lo={WIDTH{1}}. Division still takes the full latency, with no trap.
- Signed MIN ÷ −1: the magnitude path produces lo=MIN and hi=0, with no special casing.
- Unsigned magnitudes are WIDTH bits, so |MIN| = 2^(WIDTH−1) is represented without overflow.
- start while busy is ignored. The EX stage is stalled by stall_req, so the same instruction is re-presented and accepted after returning to IDLE — but only because the EX flop is held; the unit must not double-issue.
  - The held EX instruction after done is marked consumed through busy's falling edge: the unit accepts a start only if it is not the instruction just completed.
  - To achieve this, the EX stage clears start on the first unstalled cycle. The unit requires start to be low in the cycle immediately after done and ignores it if not.
- flush in any non-IDLE state returns to IDLE next cycle. hi/lo are unchanged and done is not pulsed.
- flush in IDLE suppresses a coincident start or MTHI/MTLO.
- Reset (rst==0) from any state: IDLE, hi=0, lo=0, busy=0, done=0, counter=0.

## Timing
- MUL latency from the accepting edge to hi/lo valid: WIDTH/MUL_BITS+1 cycles. This is 33 for the defaults, or 5 for MUL_BITS=8 with WIDTH=32.
- DIV latency: WIDTH+1 cycles, i.e. 33.
- MTHI/MTLO: hi/lo are visible the cycle after the accepting edge.
- hi/lo are stable except at the FIX edge, an MT* edge or reset. MFHI/MFLO see the new value on the first cycle stall_req is low.
- stall_req is low in the cycle after FIX, provided there is no new start.

## Structure
- Add md_func_e (3-bit) to the shared pipeline package alongside the EX_CTRL fields, so the MDFunc encoding has a single source.
- The state enum and counter width $clog2(WIDTH+1) stay local.
- Sub-module md_div_core: restoring divider datapath (remainder/quotient shift registers and the 1-bit step), instantiated once. The multiplier datapath is inline.

## Test plan
- Unsigned multiply, WIDTH=32, MUL_BITS=1: MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → after 33 cycles hi=0xFFFFFFFE, lo=0x00000001, done one pulse, stall_req high for 33 cycles.
- Signed multiply: MULT a=−7 (0xFFFFFFF9), b=3 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. Repeat with MUL_BITS=4 → same result, latency 9.
- Signed divide: DIV a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0. Also DIVU a=5, b=0 → hi=5, lo=0xFFFFFFFF.
- Flush abort: preload hi=0x11, lo=0x22 via MTHI/MTLO, start DIVU, assert flush on cycle 10 → busy=0 next cycle, hi=0x11, lo=0x22, no done.
- Stall interlock: hilo_read asserted during MUL → stall_req=1 until the cycle after done. A start asserted while busy causes no second operation, and the result is unchanged.
- Reset: assert rst=0 mid-DIV at cycle 20 → next cycle hi=lo=0, busy=0, stall_req=0. Release rst, then MTLO a=0xA5 → lo=0xA5 one cycle later.

Source files
------------

// File: rtl/ex_muldiv_unit_pkg.sv
// Shared EX-stage pipeline definitions: multiply/divide function encoding and EX control fields.
package ex_muldiv_unit_pkg;

    // Multiply/divide function carried in EX_CTRL. Codes 5..7 are reserved and behave as NONE.
    typedef enum logic [2:0] {
        MdNone = 3'd0,
        MdMul  = 3'd1,
        MdDiv  = 3'd2,
        MdMthi = 3'd3,
        MdMtlo = 3'd4
    } md_func_e;

    // Which architectural register an MFHI/MFLO reads.
    typedef enum logic {
        HiloSelLo = 1'b0,
        HiloSelHi = 1'b1
    } hilo_sel_e;

    // EX_CTRL fields that belong to the multiply/divide unit.
    typedef struct packed {
        md_func_e  md_func;
        logic      md_sign;
        logic      hilo_read;
        hilo_sel_e hilo_sel;
    } ex_md_ctrl_t;

    // Map a raw 3-bit function code onto md_func_e, folding reserved codes onto MdNone.
    function automatic md_func_e decode_md_func(logic [2:0] raw);
        case (raw)
            3'd1:    return MdMul;
            3'd2:    return MdDiv;
            3'd3:    return MdMthi;
            3'd4:    return MdMtlo;
            default: return MdNone;
        endcase
    endfunction

    // True for the functions that occupy the iterative datapath.
    function automatic logic is_iterative(md_func_e fn);
        return (fn == MdMul) || (fn == MdDiv);
    endfunction

endpackage

// File: rtl/md_div_core.sv
// Restoring divider datapath: one quotient bit per step on unsigned magnitudes.
module md_div_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dsr_q;
    logic [WIDTH-1:0] rem_shift;
    logic [WIDTH:0]   trial;
    logic             fits;

    // One restoring step: shift the next dividend bit in, try a subtract, keep it if no borrow.
    always_comb begin
        rem_shift = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
        trial     = {rem_q, quo_q[WIDTH-1]} - {1'b0, dsr_q};
        // Remainder is always below the divisor, so bit WIDTH of the difference is the borrow.
        fits      = ~trial[WIDTH];
    end

    // Remainder / quotient shift registers; the quotient register starts out holding the dividend.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dsr_q <= divisor;
        end else if (step) begin
            rem_q <= fits ? trial[WIDTH-1:0] : rem_shift;
            quo_q <= {quo_q[WIDTH-2:0], fits};
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO for the EX stage.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MUL_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       func,
    input  logic             is_sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hilo_read,
    input  logic             flush,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall_req
);

    localparam int unsigned CntW     = $clog2(WIDTH + 1);
    localparam int unsigned MulSteps = WIDTH / MUL_BITS;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StFix
    } state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   is_div_q;
    logic                   neg_res_q;
    logic                   neg_rem_q;
    logic                   div_zero_q;
    logic                   done_q;
    logic [2*WIDTH-1:0]     acc_q;
    logic [WIDTH-1:0]       mcand_q;
    logic [WIDTH-1:0]       hi_q;
    logic [WIDTH-1:0]       lo_q;

    md_func_e               fn;
    logic                   op_iter;
    logic                   accept;
    logic                   accept_iter;
    logic                   accept_mt;
    logic                   load;
    logic                   step_mul;
    logic                   step_div;
    logic                   fix_wr;
    logic [WIDTH-1:0]       a_mag;
    logic [WIDTH-1:0]       b_mag;
    logic [MUL_BITS-1:0]    digit;
    logic [WIDTH+MUL_BITS-1:0] pp_sum;
    logic [2*WIDTH-1:0]     acc_step;
    logic [2*WIDTH-1:0]     prod_fix;
    logic [WIDTH-1:0]       quo_raw;
    logic [WIDTH-1:0]       rem_raw;
    logic [WIDTH-1:0]       quo_fix;
    logic [WIDTH-1:0]       rem_fix;

    // Decode the request and decide whether the unit takes it this cycle.
    always_comb begin
        fn          = decode_md_func(func);
        op_iter     = is_iterative(fn);
        // done_q marks the held EX instruction that just completed; it must not issue again.
        accept      = (state_q == StIdle) && start && !flush && !done_q;
        accept_iter = accept && op_iter;
        accept_mt   = accept && ((fn == MdMthi) || (fn == MdMtlo));
        a_mag       = (is_sign && a[WIDTH-1]) ? -a : a;
        b_mag       = (is_sign && b[WIDTH-1]) ? -b : b;
    end

    // Next-state logic and datapath strobes.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load     = 1'b0;
        step_mul = 1'b0;
        step_div = 1'b0;
        fix_wr   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept_iter) begin
                    load = 1'b1;
                    if (fn == MdMul) begin
                        cnt_d   = CntW'(MulSteps);
                        state_d = StMul;
                    end else begin
                        cnt_d   = CntW'(WIDTH);
                        state_d = StDiv;
                    end
                end
            end
            StMul: begin
                step_mul = 1'b1;
                cnt_d    = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StFix;
                end
            end
            StDiv: begin
                step_div = 1'b1;
                cnt_d    = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                fix_wr  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Abort: drop the operation without touching HI/LO.
        if (flush && (state_q != StIdle)) begin
            state_d  = StIdle;
            cnt_d    = '0;
            step_mul = 1'b0;
            step_div = 1'b0;
            fix_wr   = 1'b0;
        end
    end

    // FSM state, counter and per-operation flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= fix_wr;
            if (load) begin
                is_div_q   <= (fn == MdDiv);
                neg_res_q  <= is_sign && (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_rem_q  <= is_sign && a[WIDTH-1];
                div_zero_q <= (b == '0);
            end
        end
    end

    // Shift-add multiplier: add mcand*digit into the upper half, then shift MUL_BITS right.
    always_comb begin
        digit  = acc_q[MUL_BITS-1:0];
        pp_sum = {{MUL_BITS{1'b0}}, acc_q[2*WIDTH-1:WIDTH]}
               + ({{MUL_BITS{1'b0}}, mcand_q} * {{WIDTH{1'b0}}, digit});
    end

    if (MUL_BITS < WIDTH) begin : g_mul_shift
        assign acc_step = {pp_sum, acc_q[WIDTH-1:MUL_BITS]};
    end else begin : g_mul_full
        assign acc_step = pp_sum;
    end

    // Multiplier accumulator: lower half starts as the multiplier and drains as digits retire.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q   <= '0;
            mcand_q <= '0;
        end else if (load && (fn == MdMul)) begin
            acc_q   <= {{WIDTH{1'b0}}, b_mag};
            mcand_q <= a_mag;
        end else if (step_mul) begin
            acc_q <= acc_step;
        end
    end

    md_div_core #(
        .WIDTH(WIDTH)
    ) u_div_core (
        .clk      (clk),
        .rst      (rst),
        .load     (load && (fn == MdDiv)),
        .step     (step_div),
        .dividend (a_mag),
        .divisor  (b_mag),
        .quotient (quo_raw),
        .remainder(rem_raw)
    );

    // Sign correction applied in FIX; divide-by-zero forces an all-ones quotient.
    always_comb begin
        prod_fix = neg_res_q ? -acc_q : acc_q;
        quo_fix  = div_zero_q ? {WIDTH{1'b1}} : (neg_res_q ? -quo_raw : quo_raw);
        // |a| negated gives back a, so a zero divisor also leaves hi equal to the dividend.
        rem_fix  = neg_rem_q ? -rem_raw : rem_raw;
    end

    // Architectural HI/LO: written only at the FIX edge or by an accepted MTHI/MTLO.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (fix_wr) begin
            if (is_div_q) begin
                hi_q <= rem_fix;
                lo_q <= quo_fix;
            end else begin
                hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                lo_q <= prod_fix[WIDTH-1:0];
            end
        end else if (accept_mt) begin
            if (fn == MdMthi) begin
                hi_q <= a;
            end else begin
                lo_q <= a;
            end
        end
    end

    // Status and interlock outputs.
    always_comb begin
        busy      = (state_q != StIdle);
        done      = fix_wr;
        stall_req = busy || (start && op_iter && !flush) || (hilo_read && busy);
        hi        = hi_q;
        lo        = lo_q;
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: default build plus a MUL_BITS=4 build on shared inputs.
module tb_ex_muldiv_unit;
    import ex_muldiv_unit_pkg::*;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   func;
    logic         is_sign;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         hilo_read;
    logic         flush;
    logic [W-1:0] hi, lo, hi4, lo4;
    logic         busy, done, stall_req, busy4, done4, stall4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_muldiv_unit #(.WIDTH(W), .MUL_BITS(1)) dut (
        .clk(clk), .rst(rst), .start(start), .func(func), .is_sign(is_sign), .a(a), .b(b),
        .hilo_read(hilo_read), .flush(flush), .hi(hi), .lo(lo), .busy(busy), .done(done),
        .stall_req(stall_req)
    );

    ex_muldiv_unit #(.WIDTH(W), .MUL_BITS(4)) dut_mb4 (
        .clk(clk), .rst(rst), .start(start), .func(func), .is_sign(is_sign), .a(a), .b(b),
        .hilo_read(hilo_read), .flush(flush), .hi(hi4), .lo(lo4), .busy(busy4), .done(done4),
        .stall_req(stall4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f, input logic s, input logic [W-1:0] va,
                         input logic [W-1:0] vb);
        start   = 1'b1;
        func    = f;
        is_sign = s;
        a       = va;
        b       = vb;
    endtask

    // Issue one op after an idle gap, then count busy cycles, done pulses and stall_req drops.
    task automatic run_op(input logic [2:0] f, input logic s, input logic [W-1:0] va,
                          input logic [W-1:0] vb, output int cyc, output int dones,
                          output int stall_lo);
        tick();
        drive(f, s, va, vb);
        tick();
        start    = 1'b0;
        func     = MdNone;
        cyc      = 0;
        dones    = 0;
        stall_lo = 0;
        while (busy && cyc < 100) begin
            if (done) dones++;
            if (!stall_req) stall_lo++;
            cyc++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; func = MdNone; is_sign = 1'b0; a = '0; b = '0;
        hilo_read = 1'b0; flush = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++;
        if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_req); end
    endtask

    task automatic test_signed_mul();
        int c1 = 0, c4 = 0, d1 = 0, d4 = 0;
        tick();
        drive(MdMul, 1'b1, 32'hFFFF_FFF9, 32'd3);
        #1;
        checks++;
        if (stall_req !== 1'b1 || stall4 !== 1'b1) begin
            errors++; $display("FAIL smul_start_stall: got %b/%b want 1/1", stall_req, stall4);
        end
        tick();
        start = 1'b0; func = MdNone;
        for (int i = 0; i < 40; i++) begin
            if (busy) c1++;
            if (busy4) c4++;
            if (done) d1++;
            if (done4) d4++;
            tick();
        end
        checks++; if (c1 != 33) begin errors++; $display("FAIL smul_lat_mb1: got %0d want 33", c1); end
        checks++; if (c4 != 9) begin errors++; $display("FAIL smul_lat_mb4: got %0d want 9", c4); end
        checks++;
        if (d1 != 1 || d4 != 1) begin
            errors++; $display("FAIL smul_done: got %0d/%0d want 1/1", d1, d4);
        end
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
            errors++; $display("FAIL smul_mb1: got %h_%h want ffffffff_ffffffeb", hi, lo);
        end
        checks++;
        if (hi4 !== 32'hFFFF_FFFF || lo4 !== 32'hFFFF_FFEB) begin
            errors++; $display("FAIL smul_mb4: got %h_%h want ffffffff_ffffffeb", hi4, lo4);
        end
    endtask

    task automatic test_unsigned_mul();
        int cyc, dones, slo;
        run_op(MdMul, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, dones, slo);
        checks++; if (cyc != 33) begin errors++; $display("FAIL umul_lat: got %0d want 33", cyc); end
        checks++; if (dones != 1) begin errors++; $display("FAIL umul_done: got %0d want 1", dones); end
        checks++; if (slo != 0) begin errors++; $display("FAIL umul_stall: %0d low cycles want 0", slo); end
        checks++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            errors++; $display("FAIL umul_res: got %h_%h want fffffffe_00000001", hi, lo);
        end
        checks++;
        if (stall_req !== 1'b0) begin errors++; $display("FAIL umul_after: stall %b want 0", stall_req); end
    endtask

    task automatic test_div();
        logic         sg [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] va [5] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd5, 32'd100, 32'hFFFF_FFFB};
        logic [W-1:0] vb [5] = '{32'd2, 32'hFFFF_FFFF, 32'd0, 32'd7, 32'd0};
        logic [W-1:0] eh [5] = '{32'hFFFF_FFFF, 32'h0, 32'd5, 32'd2, 32'hFFFF_FFFB};
        logic [W-1:0] el [5] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd14, 32'hFFFF_FFFF};
        int cyc, dones, slo;
        for (int i = 0; i < 5; i++) begin
            run_op(MdDiv, sg[i], va[i], vb[i], cyc, dones, slo);
            checks++;
            if (cyc != 33 || dones != 1) begin
                errors++; $display("FAIL div%0d_timing: lat %0d done %0d want 33/1", i, cyc, dones);
            end
            checks++;
            if (hi !== eh[i] || lo !== el[i]) begin
                errors++; $display("FAIL div%0d_res: got hi %h lo %h want hi %h lo %h",
                                   i, hi, lo, eh[i], el[i]);
            end
        end
    endtask

    task automatic test_mt_flush();
        int dones = 0;
        tick();
        drive(MdMthi, 1'b0, 32'h11, 32'h0);
        #1;
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL mthi_stall: got %b want 0", stall_req); end
        tick();
        start = 1'b0;
        checks++; if (hi !== 32'h11) begin errors++; $display("FAIL mthi: got %h want 11", hi); end
        drive(MdMtlo, 1'b0, 32'h22, 32'h0);
        tick();
        start = 1'b0;
        checks++; if (lo !== 32'h22) begin errors++; $display("FAIL mtlo: got %h want 22", lo); end
        // flush in IDLE swallows a coincident MTHI and MUL
        drive(MdMthi, 1'b0, 32'h99, 32'h0);
        flush = 1'b1;
        tick();
        checks++; if (hi !== 32'h11) begin errors++; $display("FAIL idle_flush_mt: got %h want 11", hi); end
        drive(MdMul, 1'b0, 32'd3, 32'd3);
        #1;
        checks++;
        if (stall_req !== 1'b0) begin errors++; $display("FAIL idle_flush_stall: got %b want 0", stall_req); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_flush_mul: busy %b want 0", busy); end
        start = 1'b0; flush = 1'b0;
        drive(MdDiv, 1'b0, 32'd100, 32'd7);
        tick();
        start = 1'b0;
        repeat (9) begin
            if (done) dones++;
            tick();
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", busy); end
        for (int i = 0; i < 40; i++) begin
            if (done) dones++;
            tick();
        end
        checks++; if (dones != 0) begin errors++; $display("FAIL flush_done: %0d pulses want 0", dones); end
        checks++;
        if (hi !== 32'h11 || lo !== 32'h22) begin
            errors++; $display("FAIL flush_hilo: got %h/%h want 11/22", hi, lo);
        end
    endtask

    task automatic test_interlock();
        int n = 0, d = 0, slo = 0;
        tick();
        hilo_read = 1'b1;
        drive(MdMul, 1'b0, 32'd6, 32'd7);
        tick();
        // start stays high as if EX re-presents the held instruction
        while (busy && n < 100) begin
            if (!stall_req) slo++;
            if (done) d++;
            n++;
            tick();
        end
        checks++;
        if (n != 33 || d != 1) begin errors++; $display("FAIL lock_timing: lat %0d done %0d want 33/1", n, d); end
        checks++; if (slo != 0) begin errors++; $display("FAIL lock_stall: %0d low cycles want 0", slo); end
        checks++;
        if (hi !== 32'h0 || lo !== 32'd42) begin errors++; $display("FAIL lock_res: got %h/%h want 0/2a", hi, lo); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lock_reissue: busy %b want 0", busy); end
        start = 1'b0;
        #1;
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL lock_release: got %b want 0", stall_req); end
        checks++; if (lo !== 32'd42) begin errors++; $display("FAIL lock_keep: lo %h want 2a", lo); end
        hilo_read = 1'b0;
    endtask

    task automatic test_reset_mid_div();
        tick();
        drive(MdDiv, 1'b1, 32'hFFFF_FFF9, 32'd2);
        tick();
        start = 1'b0;
        repeat (19) tick();
        rst = 1'b0;
        tick();
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL mid_rst_hilo: got %h/%h want 0/0", hi, lo); end
        checks++;
        if (busy !== 1'b0 || stall_req !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL mid_rst_status: busy %b stall %b done %b want 000", busy, stall_req, done);
        end
        rst = 1'b1;
        drive(MdMtlo, 1'b0, 32'hA5, 32'h0);
        tick();
        start = 1'b0;
        checks++; if (lo !== 32'hA5) begin errors++; $display("FAIL post_rst_mtlo: got %h want a5", lo); end
    endtask

    initial begin
        test_reset();
        test_signed_mul();
        test_unsigned_mul();
        test_div();
        test_mt_flush();
        test_interlock();
        test_reset_mid_div();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
